// File: rtl/blood_ph_pkg.sv
// Shared types and defaults for the blood pH analyzer.
//   ph_class_t : raw classification of one pH code (NORMAL, LOW, HIGH)
//   DEF_*      : default thresholds, persistence depth and counter width
//   classify() : combinational threshold comparison of a pH code
package blood_ph_pkg;

   localparam int unsigned PH_W        = 4;
   localparam int unsigned RUN_W       = 4;   // holds PERSIST up to 15
   localparam int unsigned DEF_LOW_TH  = 7;
   localparam int unsigned DEF_HIGH_TH = 8;
   localparam int unsigned DEF_PERSIST = 1;
   localparam int unsigned DEF_CNT_W   = 8;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      LOW    = 2'd1,
      HIGH   = 2'd2
   } ph_class_t;

   // Strict comparisons, so LOW and HIGH are exclusive whenever low_th <= high_th.
   function automatic ph_class_t classify(input logic [PH_W-1:0] ph,
                                          input int unsigned     low_th,
                                          input int unsigned     high_th);
      if (32'(ph) < low_th) begin
         return LOW;
      end else if (32'(ph) > high_th) begin
         return HIGH;
      end else begin
         return NORMAL;
      end
   endfunction

endpackage

// File: rtl/ph_run_filter.sv
// Saturating run counter plus its persistence flag for one pH class.
//   clk, rst_n   : clock and async active-low reset (already synchronised)
//   sample_valid : a sample is taken at this edge
//   hit          : the sample belongs to this filter's class
//   flag         : registered, high while the run counter equals PERSIST
module ph_run_filter
   import blood_ph_pkg::*;
#(
   parameter int unsigned PERSIST = DEF_PERSIST
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_valid,
   input  logic hit,
   output logic flag
);

   localparam logic [RUN_W-1:0] PERSIST_W = RUN_W'(PERSIST);

   logic [RUN_W-1:0] run_q, run_d;
   logic             flag_q, flag_d;

   // Any valid sample that is not ours (normal or opposite class) breaks the run.
   always_comb begin
      run_d  = run_q;
      flag_d = flag_q;
      if (sample_valid) begin
         if (!hit) begin
            run_d = '0;
         end else if (run_q != PERSIST_W) begin
            run_d = run_q + RUN_W'(1);
         end
         flag_d = (run_d == PERSIST_W);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         flag_q <= flag_d;
      end
   end

   assign flag = flag_q;

endmodule

// File: rtl/blood_ph_analyzer.sv
// Blood pH analyzer: classifies 4-bit pH codes, filters acidic/alkaline runs,
// raises a sticky alarm and optionally counts flag-assert events.
//   clk, rst_n    : clock, async active-low reset (release synchronised inline)
//   sampleValid   : bloodPH is sampled at this edge
//   bloodPH       : unsigned pH code 0..15
//   alarmClear    : clears the sticky alarm (and the event counters)
//   abnormalityP  : filtered acidic flag
//   abnormalityQ  : filtered alkaline flag
//   alarm         : sticky alarm
//   lowCount      : acidic flag-assert events (zero unless stats build)
//   highCount     : alkaline flag-assert events (zero unless stats build)
// Compile-time option: BLOOD_PH_STATS_EN enables the event counters.
module blood_ph_analyzer
   import blood_ph_pkg::*;
#(
   parameter int unsigned LOW_TH  = DEF_LOW_TH,
   parameter int unsigned HIGH_TH = DEF_HIGH_TH,
   parameter int unsigned PERSIST = DEF_PERSIST,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sampleValid,
   input  logic [PH_W-1:0]  bloodPH,
   input  logic             alarmClear,
   output logic             abnormalityP,
   output logic             abnormalityQ,
   output logic             alarm,
   output logic [CNT_W-1:0] lowCount,
   output logic [CNT_W-1:0] highCount
);

   // Reset synchroniser: assertion is immediate, release waits two edges.
   logic [1:0] sync_q, sync_d;
   logic       rst_sync_n;

   always_comb begin
      sync_d = {sync_q[0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_sync_n = sync_q[1];

   // Raw classification of the current code.
   ph_class_t cls_c;
   logic      low_flag, high_flag;

   assign cls_c = classify(bloodPH, LOW_TH, HIGH_TH);

   ph_run_filter #(.PERSIST(PERSIST)) u_low_filter (
      .clk          (clk),
      .rst_n        (rst_sync_n),
      .sample_valid (sampleValid),
      .hit          (cls_c == LOW),
      .flag         (low_flag)
   );

   ph_run_filter #(.PERSIST(PERSIST)) u_high_filter (
      .clk          (clk),
      .rst_n        (rst_sync_n),
      .sample_valid (sampleValid),
      .hit          (cls_c == HIGH),
      .flag         (high_flag)
   );

   assign abnormalityP = low_flag;
   assign abnormalityQ = high_flag;

   // Sticky alarm; a flag seen high overrides a coincident clear.
   logic alarm_q, alarm_d;

   always_comb begin
      alarm_d = alarm_q;
      if (low_flag || high_flag) begin
         alarm_d = 1'b1;
      end else if (alarmClear) begin
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
      end
   end

   assign alarm = alarm_q;

`ifdef BLOOD_PH_STATS_EN
   // Rising edges of the registered flags are detected one cycle late
   // against a delayed copy, then counted with saturation.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             low_prev_q, low_prev_d;
   logic             high_prev_q, high_prev_d;
   logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

   always_comb begin
      low_prev_d  = low_flag;
      high_prev_d = high_flag;
      low_cnt_d   = low_cnt_q;
      high_cnt_d  = high_cnt_q;
      if (low_flag && !low_prev_q) begin
         if (low_cnt_q != CNT_MAX) begin
            low_cnt_d = low_cnt_q + CNT_W'(1);
         end
      end else if (alarmClear) begin
         low_cnt_d = '0;
      end
      if (high_flag && !high_prev_q) begin
         if (high_cnt_q != CNT_MAX) begin
            high_cnt_d = high_cnt_q + CNT_W'(1);
         end
      end else if (alarmClear) begin
         high_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         low_prev_q  <= 1'b0;
         high_prev_q <= 1'b0;
         low_cnt_q   <= '0;
         high_cnt_q  <= '0;
      end else begin
         low_prev_q  <= low_prev_d;
         high_prev_q <= high_prev_d;
         low_cnt_q   <= low_cnt_d;
         high_cnt_q  <= high_cnt_d;
      end
   end

   assign lowCount  = low_cnt_q;
   assign highCount = high_cnt_q;
`else
   assign lowCount  = '0;
   assign highCount = '0;
`endif

endmodule

// File: tb/tb_blood_ph_analyzer.sv
// Self-checking bench for blood_ph_analyzer: two instances (PERSIST=1 and
// PERSIST=3) share stimulus and are compared against a streak-based model.
module tb_blood_ph_analyzer;

`ifdef BLOOD_PH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int LOW_TH  = 7;
   localparam int HIGH_TH = 8;
   localparam int PER [2] = '{1, 3};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sampleValid;
   logic [3:0] bloodPH;
   logic       alarmClear;
   logic [1:0] p_o, q_o, al_o;
   logic [7:0] lc_o [2];
   logic [7:0] hc_o [2];

   int checks = 0;
   int errors = 0;

   // Model: current streak class (0 none, 1 low, 2 high) and its length.
   int   streak_cls [2];
   int   streak_len [2];
   logic mp [2], mq [2], ma [2], older_p [2], older_q [2];
   int   lc [2], hc [2];

   always #5 clk = ~clk;

   blood_ph_analyzer #(.PERSIST(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid), .bloodPH(bloodPH),
      .alarmClear(alarmClear), .abnormalityP(p_o[0]), .abnormalityQ(q_o[0]),
      .alarm(al_o[0]), .lowCount(lc_o[0]), .highCount(hc_o[0]));

   blood_ph_analyzer #(.PERSIST(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid), .bloodPH(bloodPH),
      .alarmClear(alarmClear), .abnormalityP(p_o[1]), .abnormalityQ(q_o[1]),
      .alarm(al_o[1]), .lowCount(lc_o[1]), .highCount(hc_o[1]));

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         streak_cls[i] = 0; streak_len[i] = 0;
         mp[i] = 1'b0; mq[i] = 1'b0; ma[i] = 1'b0;
         older_p[i] = 1'b0; older_q[i] = 1'b0;
         lc[i] = 0; hc[i] = 0;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle.
   task automatic drive_edge(input bit v, input int ph, input bit clr);
      int cls;
      logic op, oq;
      @(negedge clk);
      sampleValid = v;
      bloodPH     = 4'(ph);
      alarmClear  = clr;
      @(posedge clk);
      cls = (ph < LOW_TH) ? 1 : ((ph > HIGH_TH) ? 2 : 0);
      for (int i = 0; i < 2; i++) begin
         op = mp[i];
         oq = mq[i];
         if (op || oq) ma[i] = 1'b1;
         else if (clr) ma[i] = 1'b0;
         if (op && !older_p[i]) lc[i] = (lc[i] < 255) ? lc[i] + 1 : 255;
         else if (clr) lc[i] = 0;
         if (oq && !older_q[i]) hc[i] = (hc[i] < 255) ? hc[i] + 1 : 255;
         else if (clr) hc[i] = 0;
         older_p[i] = op;
         older_q[i] = oq;
         if (v) begin
            if (cls == 0) begin
               streak_cls[i] = 0; streak_len[i] = 0;
            end else if (cls == streak_cls[i]) begin
               streak_len[i]++;
            end else begin
               streak_cls[i] = cls; streak_len[i] = 1;
            end
            mp[i] = (streak_cls[i] == 1) && (streak_len[i] >= PER[i]);
            mq[i] = (streak_cls[i] == 2) && (streak_len[i] >= PER[i]);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sampleValid = 1'b0; bloodPH = 4'd0; alarmClear = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({p_o[i], q_o[i], al_o[i], lc_o[i], hc_o[i]} !== 19'd0) begin
            errors++;
            $display("FAIL reset dut%0d got P%b Q%b A%b lc%0d hc%0d want all 0",
                     i, p_o[i], q_o[i], al_o[i], lc_o[i], hc_o[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) drive_edge(1'b0, 0, 1'b0);
   endtask

   task automatic test_directed();
      int ph_seq [9] = '{0, 7, 7, 6, 8, 15, 15, 15, 7};
      int idle   [9] = '{0, 0, 0, 0, 0, 0, 5, 0, 0};
      for (int s = 0; s < 9; s++) begin
         drive_edge(1'b1, ph_seq[s], 1'b0);
         repeat (idle[s]) drive_edge(1'b0, 15 - ph_seq[s], 1'b0);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({p_o[i], q_o[i], al_o[i]} !== {mp[i], mq[i], ma[i]}) begin
               errors++;
               $display("FAIL directed dut%0d step %0d PQA got %b%b%b want %b%b%b",
                        i, s, p_o[i], q_o[i], al_o[i], mp[i], mq[i], ma[i]);
            end
         end
      end
      // PERSIST=1 boundary: a single 0 sample flags immediately, alarm one edge later.
      drive_edge(1'b1, 0, 1'b1);
      checks++;
      if (p_o[0] !== 1'b1 || q_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL first_low_flag got P%b Q%b want P1 Q0", p_o[0], q_o[0]);
      end
      drive_edge(1'b0, 0, 1'b0);
      checks++;
      if (al_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL alarm_after_flag got %b want 1", al_o[0]);
      end
   endtask

   task automatic test_persist();
      int seq [6] = '{5, 5, 7, 5, 5, 5};
      drive_edge(1'b1, 7, 1'b0);
      for (int s = 0; s < 6; s++) begin
         drive_edge(1'b1, seq[s], 1'b0);
         checks++;
         if (p_o[1] !== ((s == 5) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL persist3 step %0d P got %b want %b", s, p_o[1], (s == 5));
         end
      end
   endtask

   task automatic test_stats();
      int  ph_seq [10] = '{7, 3, 3, 3, 7, 2, 2, 2, 7, 7};
      drive_edge(1'b1, 7, 1'b1);
      drive_edge(1'b0, 7, 1'b1);
      for (int s = 0; s < 11; s++) begin
         if (s < 10) drive_edge(1'b1, ph_seq[s], 1'b0);
         else        drive_edge(1'b0, 0, 1'b1);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (lc_o[i] !== (STATS ? 8'(lc[i]) : 8'd0) || hc_o[i] !== (STATS ? 8'(hc[i]) : 8'd0)
                || al_o[i] !== ma[i]) begin
               errors++;
               $display("FAIL stats dut%0d step %0d got lc%0d hc%0d A%b want lc%0d hc%0d A%b",
                        i, s, lc_o[i], hc_o[i], al_o[i],
                        STATS ? lc[i] : 0, STATS ? hc[i] : 0, ma[i]);
            end
         end
      end
      checks++;
      if (al_o[0] !== 1'b0 || lc_o[0] !== 8'd0) begin
         errors++;
         $display("FAIL stats_clear got A%b lc%0d want A0 lc0", al_o[0], lc_o[0]);
      end
   endtask

   task automatic test_random();
      bit v, clr;
      int ph;
      for (int s = 0; s < 400; s++) begin
         v   = ($urandom_range(0, 3) != 0);
         ph  = (s % 40 < 20) ? $urandom_range(0, 15)
                             : ((s % 80 < 60) ? $urandom_range(0, 7) : $urandom_range(8, 15));
         clr = ($urandom_range(0, 9) == 0);
         drive_edge(v, ph, clr);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({p_o[i], q_o[i], al_o[i]} !== {mp[i], mq[i], ma[i]}
                || lc_o[i] !== (STATS ? 8'(lc[i]) : 8'd0)
                || hc_o[i] !== (STATS ? 8'(hc[i]) : 8'd0)) begin
               errors++;
               $display("FAIL random dut%0d step %0d got P%b Q%b A%b lc%0d hc%0d want P%b Q%b A%b lc%0d hc%0d",
                        i, s, p_o[i], q_o[i], al_o[i], lc_o[i], hc_o[i],
                        mp[i], mq[i], ma[i], STATS ? lc[i] : 0, STATS ? hc[i] : 0);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      drive_edge(1'b1, 15, 1'b0);
      drive_edge(1'b1, 15, 1'b0);
      drive_edge(1'b1, 15, 1'b0);
      checks++;
      if (q_o !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset_q got %b want 11", q_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({p_o[i], q_o[i], al_o[i], lc_o[i], hc_o[i]} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset dut%0d got P%b Q%b A%b lc%0d hc%0d want all 0",
                     i, p_o[i], q_o[i], al_o[i], lc_o[i], hc_o[i]);
         end
      end
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) drive_edge(1'b0, 15, 1'b0);
      // First sample after synchronised release must be taken.
      drive_edge(1'b1, 1, 1'b0);
      checks++;
      if (p_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL first_sample_after_reset P got %b want 1", p_o[0]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_persist();
      test_stats();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
